// File: rtl/led_shift_pkg.sv
// Shared definitions for the LED shift register front end.
// Holds command bit positions, mode encoding and one-hot command constants.
package led_shift_pkg;

    localparam int LEFT_SHIFT  = 0;
    localparam int LOAD        = 1;
    localparam int RIGHT_SHIFT = 2;
    localparam int CLEAR       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } mode_t;

    localparam logic [3:0] CMD_NONE  = 4'b0000;
    localparam logic [3:0] CMD_LEFT  = 4'b0001;
    localparam logic [3:0] CMD_LOAD  = 4'b0010;
    localparam logic [3:0] CMD_RIGHT = 4'b0100;
    localparam logic [3:0] CMD_CLEAR = 4'b1000;

    // Steady command presented to the register for a given shift mode.
    function automatic logic [3:0] mode_cmd(input mode_t m);
        case (m)
            LEFT:    mode_cmd = CMD_LEFT;
            RIGHT:   mode_cmd = CMD_RIGHT;
            default: mode_cmd = CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, stable-sample debouncer and a
// registered one-cycle pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Any sample agreeing with the current level restarts the stability count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync2;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/led_shift_ctrl.sv
// Front-end controller for the 8-bit LED shift register: button debouncing,
// command sequencing and the period-aligned shift strobe.
module led_shift_ctrl
    import led_shift_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int STROBE_HZ = 1,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnl,
    input  logic       btnu,
    input  logic       btnr,
    input  logic       btnd,
    output logic [3:0] state,
    output logic       strobe_1hz,
    output logic       shifting
);

    localparam int DIV   = CLK_HZ / STROBE_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [3:0]       press;
    mode_t            mode;
    mode_t            mode_next;
    logic [3:0]       state_next;
    logic [CNT_W-1:0] cnt;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
        .clk   (clk),
        .rst   (rst),
        .btn   (btnl),
        .press (press[LEFT_SHIFT])
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
        .clk   (clk),
        .rst   (rst),
        .btn   (btnu),
        .press (press[LOAD])
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
        .clk   (clk),
        .rst   (rst),
        .btn   (btnr),
        .press (press[RIGHT_SHIFT])
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
        .clk   (clk),
        .rst   (rst),
        .btn   (btnd),
        .press (press[CLEAR])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode  <= IDLE;
            state <= CMD_NONE;
        end else begin
            mode  <= mode_next;
            state <= state_next;
        end
    end

    // LOAD and CLEAR are one-cycle pulses that drop back to IDLE; shift
    // buttons toggle their own mode or switch direction.
    always_comb begin
        mode_next  = mode;
        state_next = CMD_NONE;
        if (press[CLEAR]) begin
            mode_next  = IDLE;
            state_next = CMD_CLEAR;
        end else if (press[LOAD]) begin
            mode_next  = IDLE;
            state_next = CMD_LOAD;
        end else begin
            if (press[LEFT_SHIFT]) begin
                mode_next = (mode == LEFT) ? IDLE : LEFT;
            end else if (press[RIGHT_SHIFT]) begin
                mode_next = (mode == RIGHT) ? IDLE : RIGHT;
            end
            state_next = mode_cmd(mode_next);
        end
    end

    // Restarting on every mode change keeps the first shift a full period away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if ((mode_next != mode) || (mode == IDLE)) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign shifting   = (mode != IDLE);
    assign strobe_1hz = shifting && (cnt == CNT_MAX);

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Scoreboard bench for led_shift_ctrl with DIV=10 and DB_CYCLES=4.
// Stimulus queues per-cycle expectations; a monitor checks them on negedges.
module tb_led_shift_ctrl;

    typedef struct {
        int         cyc;
        logic [3:0] st;
        logic       stb;
        logic       sh;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnl = 1'b0;
    logic       btnu = 1'b0;
    logic       btnr = 1'b0;
    logic       btnd = 1'b0;
    logic [3:0] state;
    logic       strobe_1hz;
    logic       shifting;

    int   cyc = 0;
    int   vectors_applied = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    led_shift_ctrl #(
        .CLK_HZ    (100),
        .STROBE_HZ (10),
        .DB_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btnl       (btnl),
        .btnu       (btnu),
        .btnr       (btnr),
        .btnd       (btnd),
        .state      (state),
        .strobe_1hz (strobe_1hz),
        .shifting   (shifting)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int c,
                               input logic [3:0] st_exp, input logic stb_exp,
                               input logic sh_exp);
        vectors_applied++;
        if (state !== st_exp || strobe_1hz !== stb_exp || shifting !== sh_exp) begin
            miscompares++;
            $display("[TB] FAIL %s cyc=%0d got state=%b strobe=%b shifting=%b, expected state=%b strobe=%b shifting=%b",
                     name, c, state, strobe_1hz, shifting, st_exp, stb_exp, sh_exp);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            vectors_applied++;
            miscompares++;
            $display("[TB] FAIL missed_check cyc=%0d got no sample, expected one at cyc=%0d",
                     cyc, mon_e.cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_e = exp_q.pop_front();
            checkOutput("cycle", cyc, mon_e.st, mon_e.stb, mon_e.sh);
        end
    end

    task automatic expectRange(input int from, input int to, input logic [3:0] st,
                               input logic sh, input int base);
        exp_t e;
        for (int c = from; c <= to; c++) begin
            e.cyc = c;
            e.st  = st;
            e.sh  = sh;
            e.stb = sh && (((c - base) % 10) == 9);
            exp_q.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic u, input logic r, input logic d);
        btnl = l;
        btnu = u;
        btnr = r;
        btnd = d;
    endtask

    task automatic waitTo(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int t;
        int base;
        int h;
        int n;

        // Reset held for three cycles, then a quiet idle period.
        expectRange(1, 3, 4'b0000, 1'b0, 0);
        waitTo(3);
        rst = 1'b0;
        expectRange(4, 53, 4'b0000, 1'b0, 0);
        waitTo(53);

        // btnl held 20 cycles: LEFT after 8 cycles, strobes every 10.
        t = cyc;
        applyStimulus(1, 0, 0, 0);
        base = t + 8;
        expectRange(t + 1, t + 7, 4'b0000, 1'b0, 0);
        expectRange(t + 8, t + 40, 4'b0001, 1'b1, base);
        waitTo(t + 20);
        applyStimulus(0, 0, 0, 0);
        waitTo(t + 40);

        // Second btnl press pauses back to IDLE.
        t = cyc;
        applyStimulus(1, 0, 0, 0);
        expectRange(t + 1, t + 7, 4'b0001, 1'b1, base);
        expectRange(t + 8, t + 30, 4'b0000, 1'b0, 0);
        waitTo(t + 10);
        applyStimulus(0, 0, 0, 0);
        waitTo(t + 30);

        // Bounce of 2-cycle pulses, then a clean hold.
        t = cyc;
        h = t + 28;
        expectRange(t + 1, h + 7, 4'b0000, 1'b0, 0);
        expectRange(h + 8, h + 29, 4'b0001, 1'b1, h + 8);
        for (int i = 0; i < 28; i++) begin
            applyStimulus(((i / 2) % 2) == 0, 0, 0, 0);
            @(negedge clk);
        end
        applyStimulus(1, 0, 0, 0);
        waitTo(h + 12);
        applyStimulus(0, 0, 0, 0);
        waitTo(h + 29);

        // LOAD from LEFT, landing where the strobe would otherwise fire.
        t = cyc;
        applyStimulus(0, 1, 0, 0);
        expectRange(t + 1, t + 7, 4'b0001, 1'b1, h + 8);
        expectRange(t + 8, t + 8, 4'b0010, 1'b0, 0);
        expectRange(t + 9, t + 25, 4'b0000, 1'b0, 0);
        waitTo(t + 6);
        applyStimulus(0, 0, 0, 0);
        waitTo(t + 25);

        // CLEAR and RIGHT together: CLEAR wins, RIGHT dropped.
        t = cyc;
        applyStimulus(0, 0, 1, 1);
        expectRange(t + 1, t + 7, 4'b0000, 1'b0, 0);
        expectRange(t + 8, t + 8, 4'b1000, 1'b0, 0);
        expectRange(t + 9, t + 30, 4'b0000, 1'b0, 0);
        waitTo(t + 6);
        applyStimulus(0, 0, 0, 0);
        waitTo(t + 30);

        // RIGHT, then asynchronous reset when the divider sits at 7.
        t = cyc;
        applyStimulus(0, 0, 1, 0);
        expectRange(t + 1, t + 7, 4'b0000, 1'b0, 0);
        expectRange(t + 8, t + 15, 4'b0100, 1'b1, t + 8);
        expectRange(t + 16, t + 18, 4'b0000, 1'b0, 0);
        waitTo(t + 6);
        applyStimulus(0, 0, 0, 0);
        waitTo(t + 15);
        #2 rst = 1'b1;
        #1 checkOutput("async_reset", cyc, 4'b0000, 1'b0, 1'b0);
        waitTo(t + 18);
        rst = 1'b0;
        expectRange(t + 19, t + 40, 4'b0000, 1'b0, 0);
        waitTo(t + 40);

        // Fresh LEFT after reset, then RIGHT restarts the strobe period.
        t = cyc;
        applyStimulus(1, 0, 0, 0);
        expectRange(t + 1, t + 7, 4'b0000, 1'b0, 0);
        expectRange(t + 8, t + 19, 4'b0001, 1'b1, t + 8);
        expectRange(t + 20, t + 40, 4'b0100, 1'b1, t + 20);
        waitTo(t + 6);
        applyStimulus(0, 0, 0, 0);
        waitTo(t + 12);
        applyStimulus(0, 0, 1, 0);
        waitTo(t + 18);
        applyStimulus(0, 0, 0, 0);
        waitTo(t + 40);

        n = 0;
        while (exp_q.size() > 0 && n < 5) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            vectors_applied++;
            miscompares++;
            $display("[TB] FAIL drain got %0d pending, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
